// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encoding and init-sequence state types.
package sdram_pkg;

    typedef enum logic [2:0] {CMD_INHIBIT, CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_MRS} sdram_cmd_t;

    typedef enum logic [2:0] {
        POWERUP, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, MRS, WAIT_MRD, IDLE_DONE
    } init_state_t;

    localparam logic [12:0] A10_ALL_BANKS = 13'h400;

    // {cs_n, ras_n, cas_n, we_n}
    function automatic logic [3:0] cmd_bits(input sdram_cmd_t c);
        return c == CMD_NOP       ? 4'b0111 :
               c == CMD_PRECHARGE ? 4'b0010 :
               c == CMD_REFRESH   ? 4'b0001 :
               c == CMD_MRS       ? 4'b0000 : 4'b1111;
    endfunction

endpackage

// File: rtl/sdram_init_sequencer.sv
// sdram_init_sequencer: JEDEC SDRAM power-up sequence (wait, PRECHARGE ALL, N x AUTO REFRESH, MRS).
module sdram_init_sequencer
    import sdram_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int POWERUP_US = 200,
    parameter int T_RP = 2,
    parameter int T_RFC = 7,
    parameter int T_MRD = 2,
    parameter int REFRESH_COUNT = 8,
    parameter logic [12:0] MODE_REG = 13'h030
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reinit,
    output logic        init_done,
    output logic        busy,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a
);

    localparam int POWERUP_CYCLES = CLK_FREQ_MHZ * POWERUP_US;
    localparam int M1 = T_RFC > T_RP ? T_RFC : T_RP;
    localparam int M2 = T_MRD > M1 ? T_MRD : M1;
    localparam int MAX_WAIT = POWERUP_CYCLES > M2 ? POWERUP_CYCLES : M2;
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam int RW = $clog2(REFRESH_COUNT + 1);

    init_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [RW-1:0] ref_cnt, ref_d, ref_inc;
    sdram_cmd_t cmd_d;
    logic [12:0] a_d;

    assign ref_inc = ref_cnt + RW'(1);

    // Wait states leave on cnt==1 so the next command lands exactly T_x clocks after the last one.
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        ref_d = ref_cnt;
        case (state)
            POWERUP: begin
                cnt_d = cnt - CW'(1);
                state_d = cnt == '0 ? PRECHARGE : POWERUP;
            end
            PRECHARGE: begin
                cnt_d = CW'(T_RP - 1);
                state_d = T_RP == 1 ? REFRESH : WAIT_RP;
            end
            WAIT_RP: begin
                cnt_d = cnt - CW'(1);
                state_d = cnt == CW'(1) ? REFRESH : WAIT_RP;
            end
            REFRESH: begin
                ref_d = ref_inc;
                cnt_d = CW'(T_RFC - 1);
                state_d = T_RFC != 1 ? WAIT_RFC : ref_inc == RW'(REFRESH_COUNT) ? MRS : REFRESH;
            end
            WAIT_RFC: begin
                cnt_d = cnt - CW'(1);
                state_d = cnt != CW'(1) ? WAIT_RFC : ref_cnt == RW'(REFRESH_COUNT) ? MRS : REFRESH;
            end
            MRS: begin
                cnt_d = CW'(T_MRD - 1);
                state_d = T_MRD == 1 ? IDLE_DONE : WAIT_MRD;
            end
            WAIT_MRD: begin
                cnt_d = cnt - CW'(1);
                state_d = cnt == CW'(1) ? IDLE_DONE : WAIT_MRD;
            end
            IDLE_DONE: state_d = reinit ? PRECHARGE : IDLE_DONE;
        endcase
        if (state_d == PRECHARGE)
            ref_d = '0;
        cmd_d = state_d == PRECHARGE ? CMD_PRECHARGE :
                state_d == REFRESH   ? CMD_REFRESH :
                state_d == MRS       ? CMD_MRS :
                (state_d == POWERUP || state_d == IDLE_DONE) ? CMD_INHIBIT : CMD_NOP;
        a_d = state_d == PRECHARGE ? A10_ALL_BANKS : state_d == MRS ? MODE_REG : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= POWERUP;
            cnt <= CW'(POWERUP_CYCLES - 1);
            ref_cnt <= '0;
            sdram_cke <= 1'b0;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= 4'b1111;
            sdram_ba <= '0;
            sdram_a <= '0;
            init_done <= 1'b0;
            busy <= 1'b1;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            ref_cnt <= ref_d;
            sdram_cke <= 1'b1;
            {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_bits(cmd_d);
            sdram_ba <= '0;
            sdram_a <= a_d;
            init_done <= state_d == IDLE_DONE;
            busy <= state_d != IDLE_DONE;
        end
    end

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// tb_sdram_init_sequencer: three parameterisations checked every cycle against a timeline model.
module tb_sdram_init_sequencer;

    localparam int N = 3;
    localparam int PU[N]   = '{10, 3, 5};
    localparam int TRP[N]  = '{2, 1, 3};
    localparam int TRFC[N] = '{7, 1, 2};
    localparam int TMRD[N] = '{2, 1, 3};
    localparam int RC[N]   = '{8, 1, 3};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic reinit = 1'b0;
    logic done_w[N], busy_w[N], cke_w[N], cs_w[N], ras_w[N], cas_w[N], we_w[N];
    logic [1:0] ba_w[N];
    logic [12:0] a_w[N];

    int k[N];
    int since_rel;
    logic ed;
    int total = 0;
    int bad = 0;
    int nref, nmrs;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sdram_init_sequencer #(
            .CLK_FREQ_MHZ(1), .POWERUP_US(PU[g]), .T_RP(TRP[g]), .T_RFC(TRFC[g]),
            .T_MRD(TMRD[g]), .REFRESH_COUNT(RC[g]), .MODE_REG(13'h030)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .reinit(reinit),
            .init_done(done_w[g]), .busy(busy_w[g]), .sdram_cke(cke_w[g]),
            .sdram_cs_n(cs_w[g]), .sdram_ras_n(ras_w[g]), .sdram_cas_n(cas_w[g]),
            .sdram_we_n(we_w[g]), .sdram_ba(ba_w[g]), .sdram_a(a_w[g])
        );
    end

    // k = clocks since the PRECHARGE of the current sequence (negative during power-up wait).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) k[i] <= -PU[i];
            ed <= 1'b0;
            since_rel <= 0;
        end else begin
            ed <= 1'b1;
            since_rel <= since_rel + 1;
            for (int i = 0; i < N; i++)
                if (k[i] >= TRP[i] + RC[i] * TRFC[i] + TMRD[i]) begin
                    if (reinit) k[i] <= 0;
                end else k[i] <= k[i] + 1;
        end
    end

    // {cke, init_done, busy, cs_n, ras_n, cas_n, we_n, a}
    function automatic logic [19:0] model(input int i, input int kk, input logic e);
        int mrs, dn;
        logic [3:0] c;
        logic [12:0] a;
        mrs = TRP[i] + RC[i] * TRFC[i];
        dn = mrs + TMRD[i];
        c = (kk < 0 || kk >= dn) ? 4'b1111 : 4'b0111;
        a = '0;
        if (kk == 0) begin c = 4'b0010; a = 13'h400; end
        if (kk >= TRP[i] && kk < mrs && (kk - TRP[i]) % TRFC[i] == 0) c = 4'b0001;
        if (kk == mrs) begin c = 4'b0000; a = 13'h030; end
        return {e, kk >= dn, kk < dn, c, a};
    endfunction

    task automatic chk(input string nm, input int i, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] c0, c1;
        for (int i = 0; i < N; i++) begin
            chk("pins", i, {cke_w[i], done_w[i], busy_w[i], cs_w[i], ras_w[i], cas_w[i], we_w[i], a_w[i]},
                model(i, k[i], ed));
            chk("ba", i, {18'b0, ba_w[i]}, 20'd0);
        end
        c0 = {cs_w[0], ras_w[0], cas_w[0], we_w[0]};
        c1 = {cs_w[1], ras_w[1], cas_w[1], we_w[1]};
        if (since_rel == 0) begin
            chk("lit_rst_cke", 0, {19'b0, cke_w[0]}, 20'd0);
            nref = 0;
            nmrs = 0;
        end else if (since_rel <= 70) begin
            if (c0 == 4'b0001) nref++;
            if (c0 == 4'b0000) nmrs++;
        end
        if (since_rel == 9)  chk("lit_pu_inhibit", 0, {18'b0, cke_w[0], cs_w[0]}, 20'b11);
        if (since_rel == 10) chk("lit_precharge", 0, {3'b0, c0, a_w[0]}, {3'b0, 4'b0010, 13'h400});
        if (since_rel == 68) chk("lit_mrs", 0, {1'b0, c0, ba_w[0], a_w[0]}, {1'b0, 4'b0000, 2'b0, 13'h030});
        if (since_rel == 69) chk("lit_not_done", 0, {19'b0, done_w[0]}, 20'd0);
        if (since_rel == 70) begin
            chk("lit_done", 0, {19'b0, done_w[0]}, 20'd1);
            chk("lit_nref", 0, 20'(nref), 20'd8);
            chk("lit_nmrs", 0, 20'(nmrs), 20'd1);
        end
        if (since_rel == 3) chk("lit_e_pre", 1, {16'b0, c1}, 20'b0010);
        if (since_rel == 4) chk("lit_e_ref", 1, {16'b0, c1}, 20'b0001);
        if (since_rel == 5) chk("lit_e_mrs", 1, {15'b0, done_w[1], c1}, 20'b00000);
        if (since_rel == 6) chk("lit_e_done", 1, {19'b0, done_w[1]}, 20'd1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        cyc(3);
        reset_n = 1'b1;
        cyc(80);
        reinit = 1'b1; cyc(1); reinit = 1'b0;
        cyc(70);
        reinit = 1'b1; cyc(1); reinit = 1'b0;
        cyc(20);
        reinit = 1'b1; cyc(1); reinit = 1'b0;
        cyc(60);
        reinit = 1'b1; cyc(1); reinit = 1'b0;
        cyc(25);
        reset_n = 1'b0; cyc(2); reset_n = 1'b1;
        cyc(90);
        reinit = 1'b1; cyc(150); reinit = 1'b0;
        cyc(20);
        for (int n = 0; n < 2000; n++) begin
            reinit = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                cyc(1);
                reset_n = 1'b1;
            end
            cyc(1);
        end
        reinit = 1'b0;
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
